inst_fetch_unit: RTL and testbench

- CPU-side initiator for the instruction memory port (mem_itf style: addr, rmask, rdata, resp); the requesting end of the interface that the memory model answers.
- Holds the fetch PC and issues at most one outstanding word-aligned read.
- Buffers returned instructions with their PCs in a small FIFO for decode.
- Handles pipeline redirects (branch/jump flush), including discarding a response already in flight.

---
 rtl/inst_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch initiator: owns the fetch PC, keeps at most one read in
// flight on the instruction memory port and queues returned words for decode.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [3:0] RMASK_ALL = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_addr;
  logic [3:0]       r_rmask;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [31:0]      r_fifo_instr [DEPTH];
  logic [31:0]      r_fifo_pc    [DEPTH];

  state_t           w_state_nx;
  logic [31:0]      w_pc_nx;
  logic [31:0]      w_addr_nx;
  logic [3:0]       w_rmask_nx;
  logic [CNT_W-1:0] w_count_nx;
  logic [PTR_W-1:0] w_wr_ptr_nx;
  logic [PTR_W-1:0] w_rd_ptr_nx;
  logic             w_push;

  logic             w_resp;
  logic             w_pop;
  logic [31:0]      w_target;
  logic [31:0]      w_addr_inc;
  logic [CNT_W-1:0] w_count_pop;
  logic [CNT_W-1:0] w_count_push;

  // A response only counts while a request is actually outstanding.
  assign w_resp       = imem_resp & (r_rmask != 4'b0000);
  assign w_pop        = instr_valid & instr_ready & ~redirect_valid;
  assign w_target     = redirect_pc & 32'hFFFF_FFFC;
  assign w_addr_inc   = r_addr + 32'd4;
  assign w_count_pop  = r_count - CNT_W'(w_pop);
  assign w_count_push = w_count_pop + CNT_W'(1);

  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_addr_nx   = r_addr;
    w_rmask_nx  = r_rmask;
    w_count_nx  = w_count_pop;
    w_wr_ptr_nx = r_wr_ptr;
    w_rd_ptr_nx = r_rd_ptr + PTR_W'(w_pop);
    w_push      = 1'b0;

    if (redirect_valid) begin
      w_count_nx  = '0;
      w_wr_ptr_nx = '0;
      w_rd_ptr_nx = '0;
      w_pc_nx     = w_target;
    end

    case (r_state)
      S_IDLE: begin
        if (redirect_valid) begin
          w_rmask_nx = RMASK_ALL;
          w_addr_nx  = w_target;
          w_state_nx = S_WAIT;
        end else if (w_count_pop < DEPTH_C) begin
          w_rmask_nx = RMASK_ALL;
          w_addr_nx  = r_pc;
          w_state_nx = S_WAIT;
        end
      end

      S_WAIT: begin
        if (w_resp) begin
          if (redirect_valid) begin
            w_addr_nx = w_target;
          end else begin
            w_push      = 1'b1;
            w_pc_nx     = w_addr_inc;
            w_count_nx  = w_count_push;
            w_wr_ptr_nx = r_wr_ptr + PTR_W'(1);
            // Chain the next fetch on the same edge while credit remains.
            if (w_count_push < DEPTH_C) begin
              w_addr_nx = w_addr_inc;
            end else begin
              w_rmask_nx = 4'b0000;
              w_state_nx = S_IDLE;
            end
          end
        end else if (redirect_valid) begin
          w_state_nx = S_DISCARD;
        end
      end

      S_DISCARD: begin
        // Stale data is dropped; the FIFO is empty so the target can issue.
        if (w_resp) begin
          w_addr_nx  = redirect_valid ? w_target : r_pc;
          w_state_nx = S_WAIT;
        end
      end

      default: begin
        w_rmask_nx = 4'b0000;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_addr   <= RESET_PC;
      r_rmask  <= 4'b0000;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_addr   <= w_addr_nx;
      r_rmask  <= w_rmask_nx;
      r_count  <= w_count_nx;
      r_wr_ptr <= w_wr_ptr_nx;
      r_rd_ptr <= w_rd_ptr_nx;
    end
  end

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]    <= r_addr;
    end
  end

  assign imem_addr   = r_addr;
  assign imem_rmask  = r_rmask;
  assign instr_valid = (r_count != '0);
  assign instr       = r_fifo_instr[r_rd_ptr];
  assign instr_pc    = r_fifo_pc[r_rd_ptr];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: transaction-level reference model with a
// queue-based FIFO, directed scenarios with literal expectations, then random.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one request slot plus a queue of {data, pc} entries.
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;
  logic [31:0] m_addr = RESET_PC;
  logic [31:0] m_pc = RESET_PC;
  logic [63:0] m_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit rsp, input bit rdv,
                              input logic [31:0] rpc, input bit rdy,
                              input logic [31:0] data);
    bit resp_eff;
    bit pop;
    logic [31:0] tgt;
    resp_eff = m_out && rsp;
    pop = (m_q.size() != 0) && rdy;
    tgt = rpc & 32'hFFFF_FFFC;
    if (r) begin
      m_out = 1'b0;
      m_stale = 1'b0;
      m_pc = RESET_PC;
      m_addr = RESET_PC;
      m_q.delete();
    end else if (rdv) begin
      m_q.delete();
      m_pc = tgt;
      if (!m_out || resp_eff) begin
        m_out = 1'b1;
        m_addr = tgt;
        m_stale = 1'b0;
      end else begin
        m_stale = 1'b1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (resp_eff) begin
        if (m_stale) begin
          m_addr = m_pc;
          m_stale = 1'b0;
        end else begin
          m_q.push_back({data, m_addr});
          m_pc = m_addr + 32'd4;
          if (m_q.size() < DEPTH) m_addr = m_pc;
          else m_out = 1'b0;
        end
      end else if (!m_out && m_q.size() < DEPTH) begin
        m_out = 1'b1;
        m_addr = m_pc;
      end
    end
  endtask

  task automatic model_compare();
    chk("rmask", 32'(imem_rmask), m_out ? 32'h0000000F : 32'h0);
    if (m_out) chk("addr", imem_addr, m_addr);
    chk("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("instr", instr, m_q[0][63:32]);
      chk("instr_pc", instr_pc, m_q[0][31:0]);
    end
  endtask

  // Drive one cycle of inputs (at negedge), advance the model, compare next cycle.
  task automatic step(input bit r, input bit rsp, input bit rdv,
                      input logic [31:0] rpc, input bit rdy);
    logic [31:0] data;
    data = $urandom();
    rst = r;
    imem_resp = rsp;
    redirect_valid = rdv;
    redirect_pc = rpc;
    instr_ready = rdy;
    imem_rdata = data;
    model_update(r, rsp, rdv, rpc, rdy, data);
    @(posedge clk);
    @(negedge clk);
    model_compare();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    int thr;
    rst = 1'b1;
    imem_resp = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    imem_rdata = 32'h0;
    @(negedge clk);

    // Reset state, then streaming with 1-cycle memory and ready decode
    do_reset();
    chk("rst_rmask", 32'(imem_rmask), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("stream_rmask", 32'(imem_rmask), 32'h0000000F);
      chk("stream_addr", imem_addr, RESET_PC + 32'(4 * k));
      if (k > 0) chk("stream_pc", instr_pc, RESET_PC + 32'(4 * (k - 1)));
    end

    // Backpressure: FIFO fills to DEPTH, then one pop frees one request
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("full_rmask", 32'(imem_rmask), 32'h0);
    chk("full_valid", 32'(instr_valid), 32'h1);
    chk("full_head_pc", instr_pc, 32'h1eceb000);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("credit_rmask", 32'(imem_rmask), 32'h0000000F);
    chk("credit_addr", imem_addr, 32'h1eceb010);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("refull_rmask", 32'(imem_rmask), 32'h0);

    // Redirect while the memory is slow: stale response discarded
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("slow_issue", imem_addr, 32'h1eceb000);
    step(1'b0, 1'b0, 1'b1, 32'h00001003, 1'b0);
    chk("slow_hold1", imem_addr, 32'h1eceb000);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("slow_hold3", imem_addr, 32'h1eceb000);
    chk("slow_rmask", 32'(imem_rmask), 32'h0000000F);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("slow_target", imem_addr, 32'h00001000);
    chk("slow_dropped", 32'(instr_valid), 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("slow_first_pc", instr_pc, 32'h00001000);

    // Redirect coinciding with a response: no idle gap
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("same_pre_valid", 32'(instr_valid), 32'h1);
    step(1'b0, 1'b1, 1'b1, 32'h00004000, 1'b0);
    chk("same_flush", 32'(instr_valid), 32'h0);
    chk("same_addr", imem_addr, 32'h00004000);
    chk("same_rmask", 32'(imem_rmask), 32'h0000000F);

    // Two redirects during one outstanding request: only the last survives
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h00002000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h00003000, 1'b0);
    chk("dbl_hold", imem_addr, 32'h1eceb000);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("dbl_target", imem_addr, 32'h00003000);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("dbl_next", imem_addr, 32'h00003004);
    chk("dbl_head", instr_pc, 32'h00003000);

    // Reset in WAIT with resp held high
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("midrst_rmask", 32'(imem_rmask), 32'h0);
    chk("midrst_valid", 32'(instr_valid), 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("midrst_addr", imem_addr, RESET_PC);
    chk("midrst_rmask2", 32'(imem_rmask), 32'h0000000F);

    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 1'b1, 32'hFFFFFFFB, 1'b1);
    chk("wrap_a", imem_addr, 32'hFFFFFFF8);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_b", imem_addr, 32'hFFFFFFFC);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_c", imem_addr, 32'h00000000);
    chk("wrap_head", instr_pc, 32'hFFFFFFFC);

    // Random traffic; decode readiness bias changes every 100 cycles
    thr = 2;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) thr = $urandom_range(4);
      step($urandom_range(199) == 0, $urandom_range(1) == 1,
           $urandom_range(15) == 0, $urandom(), $urandom_range(3) < thr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
